// File: rtl/qpu_timing_queue.sv
// ---------------------------------------------------------------------------
// qpu_timing_queue
//
// Purpose:
//   Timestamped event queue between the QPU execution unit (EXU) and the
//   pulse/measurement back-end. Owns the global timeline counter (returned to
//   the EXU as the trigger clock), buffers timestamped events in one FIFO per
//   event lane, and releases each event as a one-cycle pulse once the timeline
//   has reached the event's timestamp.
//
// Ports:
//   clk                 core clock
//   rst_n               asynchronous active-low reset
//   trigger_i_clk_ena   timeline advances while high
//   trigger_i_clk_clr   synchronous timeline clear, also clears overflow flags
//   trigger_o_clk       current timeline value
//   trigger_i_valid     per-lane push strobe
//   trigger_i_data      per-lane {timestamp, payload}, lane k at k*(TW+EW)
//   trigger_o_full      per-lane FIFO full (from counters)
//   trigger_o_overflow  per-lane sticky "push attempted while full"
//   evt_o_valid         per-lane one-cycle release pulse
//   evt_o_data          per-lane released payload (holds between pulses)
//   evt_o_late          per-lane "released entry was overdue" (optional)
//   queue_o_empty       all lanes empty
//
// Optional feature:
//   Define QPU_TIMING_QUEUE_LATE_FLAG_EN to add the evt_o_late output.
// ---------------------------------------------------------------------------
module qpu_timing_queue #(
  parameter int EVENT_NUM   = 4,
  parameter int TIME_WIDTH  = 32,
  parameter int EVENT_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        trigger_i_clk_ena,
  input  logic                                        trigger_i_clk_clr,
  output logic [TIME_WIDTH-1:0]                       trigger_o_clk,
  input  logic [EVENT_NUM-1:0]                        trigger_i_valid,
  input  logic [EVENT_NUM*(TIME_WIDTH+EVENT_WIDTH)-1:0] trigger_i_data,
  output logic [EVENT_NUM-1:0]                        trigger_o_full,
  output logic [EVENT_NUM-1:0]                        trigger_o_overflow,
  output logic [EVENT_NUM-1:0]                        evt_o_valid,
  output logic [EVENT_NUM*EVENT_WIDTH-1:0]            evt_o_data,
`ifdef QPU_TIMING_QUEUE_LATE_FLAG_EN
  output logic [EVENT_NUM-1:0]                        evt_o_late,
`endif
  output logic                                        queue_o_empty
);

  localparam int ENTRY_WIDTH = TIME_WIDTH + EVENT_WIDTH;
  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH   = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

  logic [TIME_WIDTH-1:0]  timeline_q, timeline_d;

  logic [ENTRY_WIDTH-1:0] mem_q [EVENT_NUM][FIFO_DEPTH];
  logic [ENTRY_WIDTH-1:0] mem_d [EVENT_NUM][FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q [EVENT_NUM];
  logic [PTR_WIDTH-1:0]   wr_ptr_d [EVENT_NUM];
  logic [PTR_WIDTH-1:0]   rd_ptr_q [EVENT_NUM];
  logic [PTR_WIDTH-1:0]   rd_ptr_d [EVENT_NUM];
  logic [CNT_WIDTH-1:0]   count_q  [EVENT_NUM];
  logic [CNT_WIDTH-1:0]   count_d  [EVENT_NUM];

  logic [EVENT_NUM-1:0]   overflow_q, overflow_d;
  logic [EVENT_NUM-1:0]   evt_valid_q, evt_valid_d;
  logic [EVENT_NUM*EVENT_WIDTH-1:0] evt_data_q, evt_data_d;
`ifdef QPU_TIMING_QUEUE_LATE_FLAG_EN
  logic [EVENT_NUM-1:0]   late_q, late_d;
`endif

  logic [EVENT_NUM-1:0]   lane_full;
  logic [EVENT_NUM-1:0]   lane_empty;
  logic [EVENT_NUM-1:0]   lane_due;
  logic [EVENT_NUM-1:0]   lane_push;
  logic [EVENT_NUM-1:0]   lane_pop;
  logic [ENTRY_WIDTH-1:0] head_entry [EVENT_NUM];
  logic [TIME_WIDTH-1:0]  head_ts    [EVENT_NUM];
  logic [TIME_WIDTH-1:0]  head_age   [EVENT_NUM];

  // Timeline: clear beats enable; free-running wrap at 2^TIME_WIDTH.
  always_comb begin
    timeline_d = timeline_q;
    if (trigger_i_clk_clr) begin
      timeline_d = '0;
    end else if (trigger_i_clk_ena) begin
      timeline_d = timeline_q + TIME_WIDTH'(1);
    end
  end

  // Per-lane status. "Due" looks at the sign of (timeline - head_ts) so that
  // a timestamp just past a timeline wrap is still treated as in the future.
  always_comb begin
    for (int k = 0; k < EVENT_NUM; k++) begin
      lane_full[k]  = (count_q[k] == DEPTH_CNT);
      lane_empty[k] = (count_q[k] == '0);
      head_entry[k] = mem_q[k][rd_ptr_q[k]];
      head_ts[k]    = head_entry[k][ENTRY_WIDTH-1:EVENT_WIDTH];
      head_age[k]   = timeline_q - head_ts[k];
      lane_due[k]   = ~head_age[k][TIME_WIDTH-1];
      lane_push[k]  = trigger_i_valid[k] & ~lane_full[k];
      lane_pop[k]   = ~lane_empty[k] & lane_due[k];
    end
  end

  // FIFO bookkeeping and release stage. Full is the pre-edge value, so a
  // push into a full lane is dropped even if that lane pops this cycle.
  always_comb begin
    mem_d       = mem_q;
    overflow_d  = overflow_q;
    evt_valid_d = '0;
    evt_data_d  = evt_data_q;
`ifdef QPU_TIMING_QUEUE_LATE_FLAG_EN
    late_d      = '0;
`endif
    for (int k = 0; k < EVENT_NUM; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      count_d[k]  = count_q[k];

      if (lane_push[k]) begin
        mem_d[k][wr_ptr_q[k]] = trigger_i_data[k*ENTRY_WIDTH +: ENTRY_WIDTH];
        wr_ptr_d[k]           = wr_ptr_q[k] + PTR_WIDTH'(1);
      end

      if (lane_pop[k]) begin
        rd_ptr_d[k]                            = rd_ptr_q[k] + PTR_WIDTH'(1);
        evt_valid_d[k]                         = 1'b1;
        evt_data_d[k*EVENT_WIDTH +: EVENT_WIDTH] = head_entry[k][EVENT_WIDTH-1:0];
`ifdef QPU_TIMING_QUEUE_LATE_FLAG_EN
        late_d[k]                              = (head_ts[k] != timeline_q);
`endif
      end

      case ({lane_push[k], lane_pop[k]})
        2'b10:   count_d[k] = count_q[k] + CNT_WIDTH'(1);
        2'b01:   count_d[k] = count_q[k] - CNT_WIDTH'(1);
        default: count_d[k] = count_q[k];
      endcase

      // Clear wins over a same-cycle overflow so the EXU gets a clean slate.
      if (trigger_i_clk_clr) begin
        overflow_d[k] = 1'b0;
      end else if (trigger_i_valid[k] & lane_full[k]) begin
        overflow_d[k] = 1'b1;
      end
    end
  end

  // State registers. Storage is reset too so no X ever reaches evt_o_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeline_q  <= '0;
      overflow_q  <= '0;
      evt_valid_q <= '0;
      evt_data_q  <= '0;
`ifdef QPU_TIMING_QUEUE_LATE_FLAG_EN
      late_q      <= '0;
`endif
      for (int k = 0; k < EVENT_NUM; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[k][e] <= '0;
        end
      end
    end else begin
      timeline_q  <= timeline_d;
      overflow_q  <= overflow_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
`ifdef QPU_TIMING_QUEUE_LATE_FLAG_EN
      late_q      <= late_d;
`endif
      for (int k = 0; k < EVENT_NUM; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        count_q[k]  <= count_d[k];
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          mem_q[k][e] <= mem_d[k][e];
        end
      end
    end
  end

  assign trigger_o_clk      = timeline_q;
  assign trigger_o_full     = lane_full;
  assign trigger_o_overflow = overflow_q;
  assign evt_o_valid        = evt_valid_q;
  assign evt_o_data         = evt_data_q;
  assign queue_o_empty      = &lane_empty;
`ifdef QPU_TIMING_QUEUE_LATE_FLAG_EN
  assign evt_o_late         = late_q;
`endif

endmodule
